// File: rtl/chk_pkg.sv
// Shared types and helpers for the OR-gate vector checker.
// STOP_ON_FAIL_EN (when defined) enables the HALT state in the top.
package chk_pkg;

  localparam int N_IN_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_e;

  function automatic int num_vec(input int n_in);
    return 1 << n_in;
  endfunction

  // Vectors narrower than N_IN_MAX are zero-extended by the caller.
  function automatic logic expected_or(input logic [N_IN_MAX-1:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/or_gate_vector_checker_hold_timer.sv
// Hold-time down-counter: reload on clear, tick on the last cycle of each hold
// window, auto-reload on tick so back-to-back windows need no extra clear.
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = RELOAD;
    else if (tick_o) cnt_d = RELOAD;
    else if (en_i)   cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/or_gate_vector_checker.sv
// Sweeps every input vector onto a gate under test and checks it against OR.
// Optional STOP_ON_FAIL_EN: stop in HALT on the first mismatch.
module or_gate_vector_checker
  import chk_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec
);

  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(num_vec(N_IN) - 1);

  state_e           state_q;
  logic [N_IN-1:0]  stim_q, ffv_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, done_q, pass_q;
  logic             accept, tick, mismatch;

  // start is only honoured outside RUN; in RUN it is simply ignored.
  assign accept   = start && (state_q != RUN);
  assign mismatch = tick && (dut_out != expected_or(N_IN_MAX'(stim_q)));

  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
  end

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q == RUN),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      ffv_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (accept) begin
      state_q <= RUN;
      stim_q  <= '0;
      ffv_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (state_q == RUN && tick) begin
      err_q <= err_d;
      // err_q==0 marks the first mismatch even once the counter saturates.
      if (mismatch && (err_q == '0)) ffv_q <= stim_q;
`ifdef STOP_ON_FAIL_EN
      if (mismatch) begin
        state_q <= HALT;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        pass_q  <= 1'b0;
      end else
`endif
      if (stim_q != LAST_VEC) begin
        stim_q <= stim_q + N_IN'(1);
      end else begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        pass_q  <= (err_d == '0);
      end
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: doc/or_gate_vector_checker.md
Name: or_gate_vector_checker

Overview:
- Synthesizable, self-checking response end for the 2-input OR dataflow stimulus.
- Sequences every input combination onto a gate under test and holds each one for a fixed number of cycles.
- Samples the gate output, compares it against the expected OR of the applied vector, and reports pass/fail, error count and first failing vector.
- Sits beside the gate in the dataflow exercises as the on-chip counterpart to the stimulus-only bench.

Parameters:
- N_IN, 2, number of gate inputs; 2^N_IN vectors per run; range 1..8
- HOLD_CYCLES, 10, cycles each vector is held before sampling; minimum 2
- ERR_W, 8, width of the error counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  single-cycle run request
- stim  output  N_IN  vector driven to the gate under test; bit 0 = input a
- dut_out  input  1  gate output being checked
- busy  output  1  run in progress
- done  output  1  run finished; held until next start or reset
- pass  output  1  valid when done=1; 1 when err_count==0
- err_count  output  ERR_W  mismatches in current/last run, saturating
- first_fail_vec  output  N_IN  stim value of first mismatch; 0 if none

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n.
- Reset state, on any edge with rst_n=0, including mid-run: stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, hold_cnt=0, FSM=IDLE.
- FSM states: IDLE, RUN, DONE (plus HALT when STOP_ON_FAIL_EN is defined).
- IDLE: on start=1 → RUN; stim=0, hold_cnt=0, err_count=0, first_fail_vec=0, busy=1.
- RUN:
  - hold_cnt increments each cycle.
  - On the edge where hold_cnt==HOLD_CYCLES-1, dut_out is sampled and compared against expected = |stim (reduction OR).
  - On mismatch: err_count += 1, saturating at 2^ERR_W-1. first_fail_vec is written only on the first mismatch of the run.
  - On that same edge, if stim != 2^N_IN-1: stim += 1 and hold_cnt=0.
  - Otherwise → DONE: busy=0, done=1, pass=(err_count_next==0); stim stays at all-ones.
- Latency: done rises exactly HOLD_CYCLES*2^N_IN cycles after the start edge (40 at defaults).
- start while busy: ignored.
- DONE: start=1 → RUN with the same initialisation as IDLE; done=0 on that edge.
- No wrap-around of stim within a run; the sequence is 0..2^N_IN-1, ascending.
- dut_out is sampled only on the sample edge; glitches during settle cycles are don't-care.

Optional Feature:
- Macro: STOP_ON_FAIL_EN.
- Defined:
  - First mismatch → HALT; stim frozen at the failing vector, busy=0, done=1, pass=0, err_count=1.
  - start in HALT restarts as from DONE.
- Undefined: the full sweep always runs; HALT state is absent.

Decomposition:
- Package chk_pkg:
  - state enum (IDLE, RUN, DONE, HALT)
  - function expected_or(vec), returning the reduction OR
  - localparam NUM_VEC = 1<<N_IN helper
- Sub-module hold_timer:
  - parameterised HOLD_CYCLES down-counter with clear input and a tick output asserted on the last hold cycle.
  - The top instantiates it and steps stim on tick.

Test Plan:
- Correct OR gate, defaults, start pulse at cycle 5 → stim 0,1,2,3 each held 10 cycles; done=1 at cycle 45; pass=1, err_count=0, first_fail_vec=0.
- dut_out stuck-at-0 → err_count=3, first_fail_vec=2'b01, pass=0, done at the same cycle as the correct-gate run.
- AND gate as DUT → err_count=2 (vectors 01, 10), first_fail_vec=2'b01, pass=0.
- rst_n=0 for one cycle at cycle 20 of a run → next edge: stim=0, busy=0, err_count=0, state IDLE; a later start produces a full 40-cycle run.
- start pulsed while busy at cycle 12 → no effect on timing; start pulsed in DONE → done drops, new 40-cycle run, counters cleared.
- STOP_ON_FAIL_EN defined, stuck-at-0 DUT → done=1, 20 cycles after the start edge; stim holds 2'b01; err_count=1, pass=0.
